// File: rtl/count_bcd_display_if.sv
// Signal bundle between the counter side and the BCD display stage.
// The slave modport is the display stage; the master modport is whatever drives count.
interface count_bcd_display_if;
    logic [7:0]  count;
    logic [11:0] bcd;
    logic        valid;
    logic        busy;
    logic [6:0]  seg;
    logic [2:0]  an;

    modport master (
        output count,
        input  bcd,
        input  valid,
        input  busy,
        input  seg,
        input  an
    );

    modport slave (
        input  count,
        output bcd,
        output valid,
        output busy,
        output seg,
        output an
    );
endinterface

// File: rtl/count_bcd_display.sv
// Samples an 8-bit count, converts it to 3-digit BCD with a sequential double-dabble engine,
// and scans it onto a 3-digit 7-segment display with leading-zero blanking.
module count_bcd_display #(
    parameter int SCAN_DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    count_bcd_display_if.slave  io
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         last_cnt_q, last_cnt_d;
    logic [7:0]         sample_q, sample_d;
    logic [7:0]         bin_q, bin_d;
    logic [11:0]        work_q, work_d;
    logic [3:0]         iter_q, iter_d;
    logic [11:0]        bcd_q, bcd_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [1:0]         idx_q, idx_d;
    logic [6:0]         seg_q, seg_d;
    logic [2:0]         an_q, an_d;
    logic [11:0]        adj_s;

    // Add-3 correction applied to every BCD nibble that would overflow on the next doubling.
    function automatic logic [11:0] add3(input logic [11:0] w);
        logic [11:0] r;
        r = w;
        for (int i = 0; i < 3; i++) begin
            if (w[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = w[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = w[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Active-high {g,f,e,d,c,b,a} glyphs; non-decimal codes render dark.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b0111111;
            4'd1:    g = 7'b0000110;
            4'd2:    g = 7'b1011011;
            4'd3:    g = 7'b1001111;
            4'd4:    g = 7'b1100110;
            4'd5:    g = 7'b1101101;
            4'd6:    g = 7'b1111101;
            4'd7:    g = 7'b0000111;
            4'd8:    g = 7'b1111111;
            4'd9:    g = 7'b1101111;
            default: g = 7'b0000000;
        endcase
        return g;
    endfunction

    // Conversion FSM: sample on change, eight adjust-and-shift steps, then publish.
    always_comb begin
        state_d    = state_q;
        last_cnt_d = last_cnt_q;
        sample_d   = sample_q;
        bin_d      = bin_q;
        work_d     = work_q;
        iter_d     = iter_q;
        bcd_d      = bcd_q;
        valid_d    = 1'b0;
        busy_d     = busy_q;
        adj_s      = add3(work_q);
        case (state_q)
            IDLE: begin
                if (io.count != last_cnt_q) begin
                    sample_d = io.count;
                    bin_d    = io.count;
                    work_d   = 12'd0;
                    iter_d   = 4'd0;
                    busy_d   = 1'b1;
                    state_d  = SHIFT;
                end else begin
                    busy_d   = 1'b0;
                end
            end
            SHIFT: begin
                work_d = (adj_s << 1) | {11'd0, bin_q[7]};
                bin_d  = {bin_q[6:0], 1'b0};
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd7) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                bcd_d      = work_q;
                last_cnt_d = sample_q;
                valid_d    = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Digit scan; the hundreds digit blanks on zero, tens only when hundreds is also zero.
    always_comb begin
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d = '0;
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end else begin
            div_d = div_q + DIV_W'(1);
            idx_d = idx_q;
        end
        case (idx_q)
            2'd0: begin
                an_d  = 3'b110;
                seg_d = seg7(bcd_q[3:0]);
            end
            2'd1: begin
                an_d  = 3'b101;
                seg_d = ((bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0)) ? 7'b0000000 : seg7(bcd_q[7:4]);
            end
            2'd2: begin
                an_d  = 3'b011;
                seg_d = (bcd_q[11:8] == 4'd0) ? 7'b0000000 : seg7(bcd_q[11:8]);
            end
            default: begin
                an_d  = 3'b111;
                seg_d = 7'b0000000;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_cnt_q <= 8'd0;
            sample_q   <= 8'd0;
            bin_q      <= 8'd0;
            work_q     <= 12'd0;
            iter_q     <= 4'd0;
            bcd_q      <= 12'd0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            div_q      <= '0;
            idx_q      <= 2'd0;
            seg_q      <= 7'b0111111;
            an_q       <= 3'b110;
        end else begin
            state_q    <= state_d;
            last_cnt_q <= last_cnt_d;
            sample_q   <= sample_d;
            bin_q      <= bin_d;
            work_q     <= work_d;
            iter_q     <= iter_d;
            bcd_q      <= bcd_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign io.bcd   = bcd_q;
    assign io.valid = valid_q;
    assign io.busy  = busy_q;
    assign io.seg   = seg_q;
    assign io.an    = an_q;

endmodule

// File: tb/tb_count_bcd_display.sv
// Scoreboard bench for count_bcd_display: stimulus queues expected BCD results,
// a negedge monitor pops and checks them on every valid pulse.
module tb_count_bcd_display;

    localparam logic [6:0] G0 = 7'b0111111;
    localparam logic [6:0] G1 = 7'b0000110;
    localparam logic [6:0] G2 = 7'b1011011;
    localparam logic [6:0] G5 = 7'b1101101;
    localparam logic [6:0] G7 = 7'b0000111;
    localparam logic [6:0] BL = 7'b0000000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   run_len = 0;
    int   busy_start = 0;
    bit   prev_valid = 1'b0;
    bit   busy_seen = 1'b0;
    logic [11:0] exp_q[$];

    count_bcd_display_if io();

    count_bcd_display #(.SCAN_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: busy length, valid pulse shape, latency and scoreboard compare.
    always @(negedge clk) begin
        logic [11:0] e;
        if (!rst) begin
            run_len    = 0;
            prev_valid = 1'b0;
        end else begin
            if (io.busy) begin
                if (run_len == 0) busy_start = cyc;
                run_len++;
                busy_seen = 1'b1;
            end else if (run_len != 0) begin
                check("busy_len", run_len, 9);
                run_len = 0;
            end
            if (io.valid) begin
                check("valid_single_cycle", {31'd0, prev_valid}, 0);
                check("busy_low_at_valid", {31'd0, io.busy}, 0);
                check("latency", cyc - busy_start, 9);
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {31'd0, io.valid}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("bcd", {20'd0, io.bcd}, {20'd0, e});
                end
            end
            prev_valid = io.valid;
        end
    end

    task automatic wait_busy(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (io.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({name, "_busy_timeout"}, 0, 1);
    endtask

    task automatic wait_drain(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !io.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({name, "_drain_timeout"}, 0, 1);
    endtask

    task automatic scan_check(input string name, input logic [6:0] e_ones,
                              input logic [6:0] e_tens, input logic [6:0] e_hund);
        logic [6:0] s0 = 7'd0, s1 = 7'd0, s2 = 7'd0;
        bit seen0 = 1'b0, seen1 = 1'b0, seen2 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            case (io.an)
                3'b110:  begin s0 = io.seg; seen0 = 1'b1; end
                3'b101:  begin s1 = io.seg; seen1 = 1'b1; end
                3'b011:  begin s2 = io.seg; seen2 = 1'b1; end
                default: check({name, "_an_onehot"}, {29'd0, io.an}, {29'd0, 3'b110});
            endcase
        end
        check({name, "_seen_digits"}, {29'd0, seen2, seen1, seen0}, 3'b111);
        check({name, "_seg_ones"}, {25'd0, s0}, {25'd0, e_ones});
        check({name, "_seg_tens"}, {25'd0, s1}, {25'd0, e_tens});
        check({name, "_seg_hund"}, {25'd0, s2}, {25'd0, e_hund});
    endtask

    initial begin
        io.count = 8'd0;

        // 1: reset with count = 0, idle display
        repeat (3) @(negedge clk);
        check("rst_bcd", {20'd0, io.bcd}, 0);
        check("rst_valid", {31'd0, io.valid}, 0);
        check("rst_busy", {31'd0, io.busy}, 0);
        check("rst_an", {29'd0, io.an}, {29'd0, 3'b110});
        check("rst_seg", {25'd0, io.seg}, {25'd0, G0});
        rst = 1'b1;
        busy_seen = 1'b0;
        repeat (50) @(negedge clk);
        check("t1_no_busy", {31'd0, busy_seen}, 0);
        check("t1_bcd", {20'd0, io.bcd}, 0);
        begin
            bit found = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (io.an == 3'b101) begin
                    found = 1'b1;
                    break;
                end
            end
            check("t1_an_found", {31'd0, found}, 1);
            for (int i = 1; i < 12; i++) begin
                @(negedge clk);
                check("t1_an_seq", {29'd0, io.an},
                      {29'd0, (i < 4) ? 3'b101 : ((i < 8) ? 3'b011 : 3'b110)});
            end
        end
        scan_check("t1", G0, BL, BL);

        // 2: count = 255 already present at reset release
        @(negedge clk);
        rst = 1'b0;
        io.count = 8'd255;
        exp_q.push_back(12'h255);
        @(negedge clk);
        rst = 1'b1;
        wait_drain("t2");
        scan_check("t2", G5, G5, G2);

        // 3: single digit, both upper digits blanked
        io.count = 8'd7;
        exp_q.push_back(12'h007);
        wait_drain("t3");
        scan_check("t3", G7, BL, BL);

        // 4: change during busy is caught by an immediate second conversion
        io.count = 8'd100;
        exp_q.push_back(12'h100);
        exp_q.push_back(12'h101);
        wait_busy("t4");
        repeat (2) @(negedge clk);
        io.count = 8'd101;
        begin
            bit got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (io.valid) begin
                    got = 1'b1;
                    break;
                end
            end
            check("t4_first_valid", {31'd0, got}, 1);
            @(negedge clk);
            check("t4_restart_busy", {31'd0, io.busy}, 1);
        end
        wait_drain("t4");
        scan_check("t4", G1, G0, G1);

        // 5: reset during SHIFT aborts with no valid, then reconverts
        io.count = 8'd200;
        exp_q.push_back(12'h200);
        wait_busy("t5");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("t5_bcd", {20'd0, io.bcd}, 0);
        check("t5_valid", {31'd0, io.valid}, 0);
        check("t5_busy", {31'd0, io.busy}, 0);
        check("t5_an", {29'd0, io.an}, {29'd0, 3'b110});
        check("t5_seg", {25'd0, io.seg}, {25'd0, G0});
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_drain("t5");
        scan_check("t5", G0, G0, G2);

        // 6: down-count wrap 1 -> 0 -> 255
        io.count = 8'd1;
        exp_q.push_back(12'h001);
        repeat (12) @(negedge clk);
        io.count = 8'd0;
        exp_q.push_back(12'h000);
        repeat (12) @(negedge clk);
        scan_check("t6_zero", G0, BL, BL);
        io.count = 8'd255;
        exp_q.push_back(12'h255);
        repeat (12) @(negedge clk);
        wait_drain("t6");
        scan_check("t6_255", G5, G5, G2);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
